ahb_lite_sram_responder: RTL and testbench
==========================================

Name: ahb_lite_sram_responder

Overview:
- AHB-Lite responder (slave) that serves the processor's memory-side master port from an on-chip word-organised SRAM array.
- Sits behind the AHB interconnect on the memory bus and answers address/data-phase transfers.
- Supports programmable wait states, byte/halfword/word writes, and the two-cycle AHB ERROR response.
- Forwards write data to a read that immediately follows a write.

Parameters:
- ADDR_W, 32, HADDR width.
- DEPTH, 4096, number of 32-bit words (power of two); valid byte range is 0 .. DEPTH*4-1.
- WAIT_STATES, 0, data-phase wait cycles inserted per OKAY transfer (0..7).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_W  transfer address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 byte, 1 half, 2 word.
- HBURST  in  3  burst type; ignored, since each beat is handled independently.
- HPROT  in  4  protection; ignored.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data, data phase.

Behaviour:
- Reset (RESETN low, asynchronous):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM to IDLE; pending write and wait counter cleared.
  - SRAM contents are not reset.
  - Reset asserted mid-transfer abandons that transfer; no partial write.
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. Address, HWRITE and HSIZE are latched.
- Non-selected, IDLE or BUSY transfers with HREADY=1: zero-wait OKAY, no state change.
- Error check at accept. A transfer is an error if any of:
  - HSIZE>2;
  - misaligned address (half with HADDR[0]=1, word with HADDR[1:0]≠0);
  - HADDR ≥ DEPTH*4.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted legal transfer, go to WAIT if WAIT_STATES>0, otherwise stay in IDLE with a zero-wait data phase. On an accepted illegal transfer, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0; counter counts WAIT_STATES cycles, then returns to IDLE with HREADYOUT=1 (final data-phase cycle).
  - ERR1: HREADYOUT=0, HRESP=1; always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; goes to IDLE. An address phase presented during ERR2 is accepted normally (HREADY=1).
- Reads:
  - SRAM is read synchronously using the address latched at accept.
  - HRDATA holds the full 32-bit word, valid in the cycle HREADYOUT=1.
  - Byte lanes are not masked; the master selects lanes.
  - HRDATA keeps its last value when idle.
- Writes:
  - HWDATA is sampled in the data-phase cycle where HREADYOUT=1.
  - Byte enables come from the latched HSIZE and HADDR[1:0] (little-endian lanes).
  - The SRAM is written at that edge.
  - An ERROR transfer never writes.
- Forwarding: if a read's address phase coincides with the data-phase completion of a write to the same word, the read returns the merged word (new bytes for enabled lanes, old bytes otherwise).
- Pipelining: with WAIT_STATES=0, back-to-back transfers complete one per cycle, so full throughput is sustained.
- Latency: read data appears (WAIT_STATES+1) cycles after the accept edge.

Test Plan:
- Reset then idle: RESETN low for 3 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0; HTRANS=IDLE with HSEL=1 -> OKAY, zero wait.
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> HRDATA=0xDEADBEEF in the cycle after the read address phase (forwarded), HREADYOUT never low.
- Byte write: HSIZE=0 write 0xAA at 0x13 to a word holding 0x11223344 -> subsequent read @0x10 returns 0xAA223344.
- WAIT_STATES=2: read @0x0 -> HREADYOUT low 2 cycles, high on the 3rd with data; HRESP=0 throughout.
- Error: word read @0x2 (misaligned) -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then OKAY. Write @DEPTH*4 -> same two-cycle error and SRAM unchanged (read-back confirms).
- Reset mid-transfer: WAIT_STATES=3 write to 0x20, assert RESETN during WAIT -> outputs return to reset values immediately; later read @0x20 shows old contents.

Source files
------------

// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite responder backed by a word-organised on-chip SRAM.
// Adds programmable wait states, byte-lane writes, the two-cycle ERROR response and write-to-read forwarding.
module ahb_lite_sram_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA
);

    localparam int              IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W + 1)'(DEPTH * 4);
    localparam logic [2:0]      WAIT_LAST  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         wait_cnt;
    logic [2:0]         wait_cnt_nxt;

    logic [31:0]        mem [DEPTH];

    // Data-phase context captured at the accept edge
    logic               dp_valid;
    logic               dp_write;
    logic [IDX_W-1:0]   dp_idx;
    logic [3:0]         dp_be;
    logic [31:0]        rdata_q;

    logic               accept;
    logic               addr_err;
    logic               dp_done;
    logic               wr_fire;
    logic [IDX_W-1:0]   a_idx;
    logic [3:0]         a_be;
    logic [31:0]        rd_word;

    logic               unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

    assign a_idx   = HADDR[IDX_W+1:2];
    assign accept  = HSEL & HTRANS[1] & HREADY & ((state == S_IDLE) || (state == S_ERR2));
    assign dp_done = dp_valid & (state == S_IDLE);
    assign wr_fire = dp_done & dp_write;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        addr_err = ({1'b0, HADDR} >= BYTE_LIMIT);
        case (HSIZE)
            3'd0:    ;
            3'd1:    if (HADDR[0]) addr_err = 1'b1;
            3'd2:    if (HADDR[1:0] != 2'b00) addr_err = 1'b1;
            default: addr_err = 1'b1;
        endcase
    end

    always_comb begin
        a_be = 4'b1111;
        case (HSIZE)
            3'd0:    a_be = 4'b0001 << HADDR[1:0];
            3'd1:    a_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase
    end

    // A read accepted on the edge that completes a write to the same word sees the merged word.
    always_comb begin
        rd_word = mem[a_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_fire && (dp_idx == a_idx) && dp_be[i]) begin
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = 3'd0;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= 4'b0000;
            rdata_q  <= 32'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                dp_valid <= ~addr_err;
                dp_write <= HWRITE;
                dp_idx   <= a_idx;
                dp_be    <= a_be;
                if (!addr_err && !HWRITE) begin
                    rdata_q <= rd_word;
                end
            end else if (dp_done) begin
                dp_valid <= 1'b0;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto an SRAM macro; only its control path is reset.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be[i]) begin
                    mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// Bench for ahb_lite_sram_responder: three instances (0, 2 and 3 wait states) driven by a
// pipelined AHB master model; a scoreboard queue holds the expected completion of each transfer.
module tb_ahb_lite_sram_responder;

    localparam int DEPTH = 4096;
    localparam int MAX_CYCLES = 200;

    typedef struct {
        bit          idle;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        string       name;
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;

    logic        rdy0, rdy1, rdy2;
    logic        rsp0, rsp1, rsp2;
    logic [31:0] rdt0, rdt1, rdt2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [int];
    exp_t        sb [$];

    ahb_lite_sram_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RESETN(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rdt0)
    );

    ahb_lite_sram_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .CLK(clk), .RESETN(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(rsp1), .HRDATA(rdt1)
    );

    ahb_lite_sram_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .CLK(clk), .RESETN(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy2), .HREADYOUT(rdy2), .HRESP(rsp2), .HRDATA(rdt2)
    );

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic xfer_t mk(input bit w, input logic [31:0] a, input logic [2:0] s,
                                 input logic [31:0] wd);
        xfer_t t;
        t.idle = 1'b0; t.write = w; t.addr = a; t.size = s; t.wdata = wd;
        return t;
    endfunction

    function automatic xfer_t mk_idle();
        xfer_t t;
        t.idle = 1'b1; t.write = 1'b0; t.addr = 32'h0; t.size = 3'd0; t.wdata = 32'h0;
        return t;
    endfunction

    function automatic bit is_err(input xfer_t t);
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 32'd0) return 1'b1;
        return t.addr >= 32'(DEPTH * 4);
    endfunction

    task automatic sample(input int d, output logic r, output logic e, output logic [31:0] q);
        case (d)
            0:       begin r = rdy0; e = rsp0; q = rdt0; end
            1:       begin r = rdy1; e = rsp1; q = rdt1; end
            default: begin r = rdy2; e = rsp2; q = rdt2; end
        endcase
    endtask

    task automatic bus_idle();
        hsel   = 3'b000;
        haddr  = 32'h0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
    endtask

    // Builds the expected completion of an accepted transfer and applies writes to the model.
    task automatic push_expect(input int d, input xfer_t t, input int idx);
        exp_t        x;
        int          key;
        logic [31:0] w;
        x.name  = $sformatf("dut%0d_x%0d_%s@%h", d, idx, t.write ? "wr" : "rd", t.addr);
        x.err   = is_err(t);
        x.rd    = ~t.write;
        x.waits = x.err ? 1 : ws_of(d);
        x.data  = 32'hx;
        if (!x.err) begin
            key = d * DEPTH + int'(t.addr[13:2]);
            w   = mdl.exists(key) ? mdl[key] : 32'hx;
            if (t.write) begin
                for (int b = 0; b < (1 << t.size); b++) begin
                    int lane;
                    lane = int'(t.addr[1:0]) + b;
                    w[8*lane +: 8] = t.wdata[8*lane +: 8];
                end
                mdl[key] = w;
            end else begin
                x.data = w;
            end
        end
        sb.push_back(x);
    endtask

    // Pipelined master: address phase of transfer i overlaps the data phase of transfer i-1.
    task automatic run(input int d, input xfer_t seq [$]);
        int          i = 0;
        int          cyc = 0;
        int          waits = 0;
        bit          dp_v = 1'b0;
        bit          dp_w = 1'b0;
        bit          resp_ok = 1'b1;
        logic [31:0] dp_wd = 32'h0;
        logic        r, e;
        logic [31:0] q;
        exp_t        x;
        while ((i < seq.size() || dp_v) && cyc < MAX_CYCLES) begin
            bus_idle();
            if (i < seq.size()) begin
                hsel[d] = 1'b1;
                haddr   = seq[i].addr;
                htrans  = seq[i].idle ? 2'b00 : 2'b10;
                hwrite  = seq[i].write;
                hsize   = seq[i].size;
            end
            hwdata = (dp_v && dp_w) ? dp_wd : 32'h0;
            @(negedge clk);
            sample(d, r, e, q);
            if (dp_v) begin
                if (!r) begin
                    waits++;
                    if (e !== sb[0].err) resp_ok = 1'b0;
                end else begin
                    x = sb.pop_front();
                    n_cmp++;
                    if (waits != x.waits) begin
                        n_bad++;
                        $display("FAIL %s waits: got %0d want %0d", x.name, waits, x.waits);
                    end
                    n_cmp++;
                    if (!resp_ok) begin
                        n_bad++;
                        $display("FAIL %s wait_resp: HRESP during wait differed from %0b", x.name, x.err);
                    end
                    n_cmp++;
                    if (e !== x.err) begin
                        n_bad++;
                        $display("FAIL %s hresp: got %b want %b", x.name, e, x.err);
                    end
                    if (x.rd && !x.err) begin
                        n_cmp++;
                        if (q !== x.data) begin
                            n_bad++;
                            $display("FAIL %s hrdata: got %h want %h", x.name, q, x.data);
                        end
                    end
                    dp_v    = 1'b0;
                    waits   = 0;
                    resp_ok = 1'b1;
                end
            end
            if (r && i < seq.size()) begin
                if (!seq[i].idle) begin
                    push_expect(d, seq[i], i);
                    dp_v  = 1'b1;
                    dp_w  = seq[i].write;
                    dp_wd = seq[i].wdata;
                end
                i++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_idle();
        hwdata = 32'h0;
        if (i < seq.size() || dp_v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d timeout: %0d of %0d transfers issued after %0d cycles",
                     d, i, seq.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        logic        r, e;
        logic [31:0] q;
        rst_n  = 1'b0;
        bus_idle();
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sample(d, r, e, q);
            n_cmp++;
            if (r !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout dut%0d: got %b want 1", d, r); end
            n_cmp++;
            if (e !== 1'b0) begin n_bad++; $display("FAIL reset_hresp dut%0d: got %b want 0", d, e); end
            n_cmp++;
            if (q !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata dut%0d: got %h want 0", d, q); end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            hsel   = (k < 2) ? 3'b111 : 3'b000;
            htrans = (k == 1) ? 2'b01 : 2'b00;
            haddr  = 32'h10;
            hwrite = 1'b1;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                sample(d, r, e, q);
                n_cmp++;
                if (r !== 1'b1 || e !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_okay dut%0d step%0d: got rdy=%b resp=%b want rdy=1 resp=0", d, k, r, e);
                end
            end
            @(posedge clk);
            #1;
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        xfer_t s [$];
        s.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        s.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        s.push_back(mk(1'b1, 32'h14, 3'd2, 32'h01234567));
        s.push_back(mk(1'b1, 32'h18, 3'd2, 32'h89ABCDEF));
        s.push_back(mk(1'b0, 32'h14, 3'd2, 32'h0));
        s.push_back(mk(1'b0, 32'h18, 3'd2, 32'h0));
        s.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        run(0, s);
    endtask

    task automatic test_byte_write();
        xfer_t s [$];
        s.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
        s.push_back(mk_idle());
        s.push_back(mk(1'b1, 32'h13, 3'd0, 32'hAA5A5A5A));
        s.push_back(mk_idle());
        s.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        s.push_back(mk(1'b1, 32'h11, 3'd0, 32'h5A5ABB5A));
        s.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
        s.push_back(mk(1'b1, 32'h1C, 3'd2, 32'h00000000));
        s.push_back(mk(1'b1, 32'h1E, 3'd1, 32'hC0DE7777));
        s.push_back(mk_idle());
        s.push_back(mk(1'b0, 32'h1C, 3'd2, 32'h0));
        run(0, s);
    endtask

    task automatic test_wait_states();
        xfer_t s [$];
        s.push_back(mk(1'b1, 32'h0, 3'd2, 32'h01020304));
        s.push_back(mk_idle());
        s.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
        s.push_back(mk(1'b1, 32'h4, 3'd2, 32'hFFFF0000));
        s.push_back(mk(1'b1, 32'h6, 3'd1, 32'h1234ABCD));
        s.push_back(mk(1'b0, 32'h4, 3'd2, 32'h0));
        s.push_back(mk(1'b0, 32'h2, 3'd2, 32'h0));
        s.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
        run(1, s);
    endtask

    task automatic test_errors();
        xfer_t s [$];
        s.push_back(mk(1'b1, 32'h0, 3'd2, 32'h12345678));
        s.push_back(mk(1'b0, 32'h2, 3'd2, 32'h0));
        s.push_back(mk_idle());
        s.push_back(mk(1'b1, 32'(DEPTH * 4), 3'd2, 32'hBAD0BAD0));
        s.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
        s.push_back(mk(1'b1, 32'h1, 3'd1, 32'hFFFFFFFF));
        s.push_back(mk(1'b0, 32'h0, 3'd3, 32'h0));
        s.push_back(mk(1'b1, 32'(DEPTH * 4 - 4), 3'd2, 32'h7E7E7E7E));
        s.push_back(mk(1'b0, 32'(DEPTH * 4 - 4), 3'd2, 32'h0));
        s.push_back(mk(1'b0, 32'h0, 3'd2, 32'h0));
        run(0, s);
    endtask

    task automatic test_reset_mid();
        xfer_t       s [$];
        logic        r, e;
        logic [31:0] q;
        s.push_back(mk(1'b1, 32'h20, 3'd2, 32'hCAFEF00D));
        s.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
        run(2, s);
        hsel   = 3'b100;
        haddr  = 32'h20;
        htrans = 2'b10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        @(posedge clk);
        #1;
        bus_idle();
        hwdata = 32'h0BADF00D;
        @(negedge clk);
        sample(2, r, e, q);
        n_cmp++;
        if (r !== 1'b0) begin n_bad++; $display("FAIL mid_wait_hreadyout: got %b want 0", r); end
        #2;
        rst_n = 1'b0;
        #1;
        sample(2, r, e, q);
        n_cmp++;
        if (r !== 1'b1 || e !== 1'b0 || q !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got rdy=%b resp=%b data=%h want 1 0 00000000", r, e, q);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        hwdata = 32'h0;
        @(posedge clk);
        #1;
        s.delete();
        s.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
        run(2, s);
    endtask

    initial begin
        hburst = 3'b000;
        hprot  = 4'b0011;
        test_reset();
        test_back_to_back();
        test_byte_write();
        test_wait_states();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
